// File: rtl/segasys_sound_mailbox.sv
// Main-CPU -> sound-CPU command mailbox: DEPTH-entry FIFO or classic overwrite
// latch, with a retriggerable NMI pulse and level/overflow status.
module segasys_sound_mailbox #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int MODE    = 1,
  parameter int NMI_LEN = 16
)(
  input  logic                         clk40M,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic                         pending,
  output logic                         nmi,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic       nmi_trig;
  logic [7:0] nmi_cnt;

  // Any new head reloads the counter, so back-to-back triggers keep nmi high.
  always_ff @(posedge clk40M or negedge reset_n) begin
    if (!reset_n)              nmi_cnt <= 8'd0;
    else if (nmi_trig)         nmi_cnt <= 8'(NMI_LEN);
    else if (nmi_cnt != 8'd0)  nmi_cnt <= nmi_cnt - 8'd1;
  end

  assign nmi = (nmi_cnt != 8'd0);

  generate
    if (MODE == 0) begin : g_latch
      logic flag;

      always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
          rd_data <= '0;
          flag    <= 1'b0;
        end else if (wr_en) begin
          rd_data <= wr_data;
          flag    <= 1'b1;
        end else if (rd_en) begin
          flag    <= 1'b0;
        end
      end

      assign nmi_trig = wr_en;
      assign pending  = flag;
      assign level    = LW'(flag);
      assign full     = 1'b0;
      assign overflow = 1'b0;
    end else begin : g_fifo
      localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);
      localparam logic [LW-1:0] ONE_LV  = LW'(1);

      logic [DEPTH-1:0][DW-1:0] mem;
      logic [PW-1:0]            wr_ptr, rd_ptr, rd_nxt;
      logic [LW-1:0]            cnt;
      logic                     ovf_q;
      logic                     is_full, is_empty;
      logic                     wr_acc, rd_acc, drop, head_load, pop_more;

      assign is_full   = (cnt == FULL_LV);
      assign is_empty  = (cnt == '0);
      // A full FIFO still accepts a write when a pop frees the head slot.
      assign wr_acc    = wr_en && (!is_full || rd_en);
      assign rd_acc    = rd_en && !is_empty;
      assign drop      = wr_en && is_full && !rd_en;
      assign head_load = wr_acc && is_empty;
      assign pop_more  = rd_acc && ((cnt != ONE_LV) || wr_acc);
      assign rd_nxt    = rd_ptr + PW'(1);
      assign nmi_trig  = head_load || pop_more;

      always_ff @(posedge clk40M) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
      end

      always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          cnt     <= '0;
          rd_data <= '0;
          ovf_q   <= 1'b0;
        end else begin
          if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
          if (rd_acc) rd_ptr <= rd_nxt;
          case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + ONE_LV;
            2'b01:   cnt <= cnt - ONE_LV;
            default: cnt <= cnt;
          endcase
          // With one entry, a write+pop makes the incoming word the new head
          // before it lands in mem, so bypass it.
          if (head_load)
            rd_data <= wr_data;
          else if (pop_more)
            rd_data <= (wr_acc && cnt == ONE_LV) ? wr_data : mem[rd_nxt];
          if (drop)         ovf_q <= 1'b1;
          else if (ovf_clr) ovf_q <= 1'b0;
        end
      end

      assign pending  = !is_empty;
      assign level    = cnt;
      assign full     = is_full;
      assign overflow = ovf_q;
    end
  endgenerate

endmodule

// File: tb/tb_segasys_sound_mailbox.sv
// Directed bench: one FIFO-mode and one latch-mode mailbox, hand-computed expectations.
module tb_segasys_sound_mailbox;

  logic       clk40M = 1'b0;
  logic       reset_n = 1'b0;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_ovf_clr = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic [7:0] f_rd_data;
  logic       f_pending, f_nmi, f_full, f_overflow;
  logic [2:0] f_level;

  logic       l_wr_en = 1'b0, l_rd_en = 1'b0, l_ovf_clr = 1'b0;
  logic [7:0] l_wr_data = 8'h00;
  logic [7:0] l_rd_data;
  logic       l_pending, l_nmi, l_full, l_overflow;
  logic [2:0] l_level;

  int checks = 0;
  int errors = 0;

  always #5 clk40M = ~clk40M;

  segasys_sound_mailbox #(.DW(8), .DEPTH(4), .MODE(1), .NMI_LEN(16)) u_fifo (
    .clk40M(clk40M), .reset_n(reset_n), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .pending(f_pending), .nmi(f_nmi),
    .level(f_level), .full(f_full), .overflow(f_overflow), .ovf_clr(f_ovf_clr));

  segasys_sound_mailbox #(.DW(8), .DEPTH(4), .MODE(0), .NMI_LEN(16)) u_latch (
    .clk40M(clk40M), .reset_n(reset_n), .wr_en(l_wr_en), .wr_data(l_wr_data),
    .rd_en(l_rd_en), .rd_data(l_rd_data), .pending(l_pending), .nmi(l_nmi),
    .level(l_level), .full(l_full), .overflow(l_overflow), .ovf_clr(l_ovf_clr));

  task automatic tick();
    @(posedge clk40M); #1;
  endtask

  task automatic test_reset();
    checks++; if (f_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", f_level); end
    checks++; if (f_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", f_rd_data); end
    checks++; if ({f_pending, f_nmi, f_full, f_overflow} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b exp 0000", {f_pending, f_nmi, f_full, f_overflow}); end
    checks++; if ({l_pending, l_nmi, l_level} !== 5'b0) begin errors++; $display("FAIL reset_latch got %b exp 0", {l_pending, l_nmi, l_level}); end
  endtask

  task automatic test_fifo_basic();
    int n_hi;
    f_wr_en = 1'b1; f_wr_data = 8'h11; tick();
    checks++; if (f_rd_data !== 8'h11) begin errors++; $display("FAIL basic_first_head got %h exp 11", f_rd_data); end
    checks++; if ({f_nmi, f_pending} !== 2'b11) begin errors++; $display("FAIL basic_nmi_start got %b exp 11", {f_nmi, f_pending}); end
    n_hi = int'(f_nmi);
    f_wr_data = 8'h22; tick(); n_hi += int'(f_nmi);
    f_wr_data = 8'h33; tick(); n_hi += int'(f_nmi);
    f_wr_en = 1'b0;
    checks++; if (f_level !== 3'd3) begin errors++; $display("FAIL basic_level3 got %0d exp 3", f_level); end
    checks++; if (f_rd_data !== 8'h11) begin errors++; $display("FAIL basic_head_hold got %h exp 11", f_rd_data); end
    for (int i = 0; i < 40 && f_nmi; i++) begin tick(); n_hi += int'(f_nmi); end
    checks++; if (n_hi != 16) begin errors++; $display("FAIL basic_nmi_len got %0d exp 16", n_hi); end

    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    checks++; if ({f_rd_data, f_level} !== {8'h22, 3'd2}) begin errors++; $display("FAIL pop1 got %h/%0d exp 22/2", f_rd_data, f_level); end
    n_hi = int'(f_nmi);
    for (int i = 0; i < 40 && f_nmi; i++) begin tick(); n_hi += int'(f_nmi); end
    checks++; if (n_hi != 16) begin errors++; $display("FAIL pop1_nmi_len got %0d exp 16", n_hi); end

    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    checks++; if ({f_rd_data, f_level, f_nmi} !== {8'h33, 3'd1, 1'b1})
      begin errors++; $display("FAIL pop2 got %h/%0d/%b exp 33/1/1", f_rd_data, f_level, f_nmi); end
    for (int i = 0; i < 40 && f_nmi; i++) tick();

    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    checks++; if ({f_rd_data, f_level, f_pending, f_nmi} !== {8'h33, 3'd0, 1'b0, 1'b0})
      begin errors++; $display("FAIL pop3_empty got %h/%0d/%b/%b exp 33/0/0/0", f_rd_data, f_level, f_pending, f_nmi); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_q [4];
    for (int i = 1; i <= 5; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'(i); tick();
      if (i == 4) begin
        checks++; if ({f_full, f_overflow} !== 2'b10) begin errors++; $display("FAIL full_after4 got %b exp 10", {f_full, f_overflow}); end
      end
    end
    f_wr_en = 1'b0;
    checks++; if ({f_level, f_full, f_overflow} !== {3'd4, 1'b1, 1'b1})
      begin errors++; $display("FAIL drop5 got %0d/%b/%b exp 4/1/1", f_level, f_full, f_overflow); end
    f_wr_en = 1'b1; f_wr_data = 8'hEE; f_ovf_clr = 1'b1; tick(); f_wr_en = 1'b0;
    checks++; if ({f_overflow, f_level} !== {1'b1, 3'd4}) begin errors++; $display("FAIL clr_vs_drop got %b/%0d exp 1/4", f_overflow, f_level); end
    tick(); f_ovf_clr = 1'b0;
    checks++; if (f_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", f_overflow); end
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      checks++; if (f_rd_data !== exp_q[i]) begin errors++; $display("FAIL full_pop%0d got %h exp %h", i, f_rd_data, exp_q[i]); end
      f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    end
    checks++; if ({f_level, f_rd_data} !== {3'd0, 8'h04}) begin errors++; $display("FAIL full_drained got %0d/%h exp 0/04", f_level, f_rd_data); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q [4];
    for (int i = 0; i < 4; i++) begin f_wr_en = 1'b1; f_wr_data = 8'hA0 + 8'(i); tick(); end
    f_wr_data = 8'hAA; f_rd_en = 1'b1; tick(); f_wr_en = 1'b0; f_rd_en = 1'b0;
    checks++; if ({f_level, f_full, f_overflow, f_rd_data} !== {3'd4, 1'b1, 1'b0, 8'hA1})
      begin errors++; $display("FAIL sim_full got %0d/%b/%b/%h exp 4/1/0/a1", f_level, f_full, f_overflow, f_rd_data); end
    exp_q = '{8'hA2, 8'hA3, 8'hAA, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
      checks++; if (f_rd_data !== exp_q[i]) begin errors++; $display("FAIL sim_pop%0d got %h exp %h", i, f_rd_data, exp_q[i]); end
    end
    for (int i = 0; i < 40 && f_nmi; i++) tick();
    f_wr_en = 1'b1; f_wr_data = 8'h55; f_rd_en = 1'b1; tick();
    checks++; if ({f_level, f_rd_data, f_nmi} !== {3'd1, 8'h55, 1'b1})
      begin errors++; $display("FAIL sim_empty got %0d/%h/%b exp 1/55/1", f_level, f_rd_data, f_nmi); end
    f_wr_data = 8'h66; tick(); f_wr_en = 1'b0; f_rd_en = 1'b0;
    checks++; if ({f_level, f_rd_data} !== {3'd1, 8'h66}) begin errors++; $display("FAIL sim_level1 got %0d/%h exp 1/66", f_level, f_rd_data); end
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
  endtask

  task automatic test_read_empty();
    for (int i = 0; i < 40 && f_nmi; i++) tick();
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    checks++; if ({f_level, f_nmi, f_pending, f_rd_data} !== {3'd0, 1'b0, 1'b0, 8'h66})
      begin errors++; $display("FAIL rd_empty got %0d/%b/%b/%h exp 0/0/0/66", f_level, f_nmi, f_pending, f_rd_data); end
    f_wr_en = 1'b1; f_wr_data = 8'h77; tick(); f_wr_data = 8'h78; tick(); f_wr_en = 1'b0;
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
    checks++; if ({f_level, f_rd_data} !== {3'd1, 8'h78}) begin errors++; $display("FAIL rd_empty_ptr got %0d/%h exp 1/78", f_level, f_rd_data); end
    f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
  endtask

  task automatic test_latch();
    int n_hi;
    l_wr_en = 1'b1; l_wr_data = 8'h10; tick(); l_wr_en = 1'b0;
    checks++; if ({l_rd_data, l_pending, l_nmi, l_level} !== {8'h10, 1'b1, 1'b1, 3'd1})
      begin errors++; $display("FAIL latch_wr1 got %h/%b/%b/%0d exp 10/1/1/1", l_rd_data, l_pending, l_nmi, l_level); end
    repeat (5) tick();
    l_wr_en = 1'b1; l_wr_data = 8'h20; tick(); l_wr_en = 1'b0;
    checks++; if (l_rd_data !== 8'h20) begin errors++; $display("FAIL latch_overwrite got %h exp 20", l_rd_data); end
    n_hi = int'(l_nmi);
    for (int i = 0; i < 40 && l_nmi; i++) begin tick(); n_hi += int'(l_nmi); end
    checks++; if (n_hi != 16) begin errors++; $display("FAIL latch_nmi_restart got %0d exp 16", n_hi); end
    l_rd_en = 1'b1; tick(); l_rd_en = 1'b0;
    checks++; if ({l_pending, l_rd_data, l_level, l_nmi} !== {1'b0, 8'h20, 3'd0, 1'b0})
      begin errors++; $display("FAIL latch_read got %b/%h/%0d/%b exp 0/20/0/0", l_pending, l_rd_data, l_level, l_nmi); end
    l_wr_en = 1'b1; l_wr_data = 8'h30; l_rd_en = 1'b1; tick(); l_wr_en = 1'b0; l_rd_en = 1'b0;
    checks++; if ({l_pending, l_rd_data, l_full, l_overflow} !== {1'b1, 8'h30, 1'b0, 1'b0})
      begin errors++; $display("FAIL latch_wr_rd got %b/%h/%b/%b exp 1/30/0/0", l_pending, l_rd_data, l_full, l_overflow); end
  endtask

  task automatic test_async_reset();
    f_wr_en = 1'b1;
    f_wr_data = 8'h91; tick(); f_wr_data = 8'h92; tick(); f_wr_data = 8'h93; tick();
    f_wr_en = 1'b0;
    checks++; if ({f_level, f_nmi} !== {3'd3, 1'b1}) begin errors++; $display("FAIL ar_setup got %0d/%b exp 3/1", f_level, f_nmi); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({f_nmi, f_pending, f_level, f_rd_data, f_full} !== {1'b0, 1'b0, 3'd0, 8'h00, 1'b0})
      begin errors++; $display("FAIL ar_immediate got %b/%b/%0d/%h exp 0/0/0/00", f_nmi, f_pending, f_level, f_rd_data); end
    checks++; if ({l_nmi, l_pending, l_rd_data} !== {1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL ar_latch got %b/%b/%h exp 0/0/00", l_nmi, l_pending, l_rd_data); end
    @(negedge clk40M); reset_n = 1'b1;
    f_wr_en = 1'b1; f_wr_data = 8'h44; tick(); f_wr_en = 1'b0;
    checks++; if ({f_level, f_rd_data} !== {3'd1, 8'h44}) begin errors++; $display("FAIL ar_after got %0d/%h exp 1/44", f_level, f_rd_data); end
  endtask

  initial begin
    repeat (2) @(posedge clk40M);
    @(negedge clk40M); reset_n = 1'b1;
    tick();
    test_reset();
    test_fifo_basic();
    test_fifo_full();
    test_simultaneous();
    test_read_empty();
    test_latch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
